// File: rtl/ysyx_23060072_ex_stage.sv
// rtl/ysyx_23060072_ex_stage.sv - RV32E execute stage: single-cycle ALU, iterative mul/div, ex->lsu register
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   valid_i, alu_op_i               instruction from decode and its ALU/M operation
//   alu_src_imm_i                   operand B = operand_imm_i when set, else operand_b_i
//   operand_a_i/_b_i/_imm_i         rs1, rs2, immediate
//   wb/store/load/LSU_signed/LSU_type/wb_addr _i   control passed through to the LSU stage
//   lsu_hold_i                      LSU busy: freeze the ex->lsu register
//   flush_i                         kill the instruction currently in EX
//   ex_hold_flag_o                  mul/div in progress, hold IF/ID
//   *_o (others)                    registered ex->lsu bundle, wb_data_o = execute result
module ysyx_23060072_ex_stage #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [4:0]      alu_op_i,
    input  logic            alu_src_imm_i,
    input  logic            wb_flag_i,
    input  logic            store_flag_i,
    input  logic            load_flag_i,
    input  logic            LSU_signed_i,
    input  logic [1:0]      LSU_type_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [XLEN-1:0] operand_imm_i,
    input  logic            lsu_hold_i,
    input  logic            flush_i,
    output logic            ex_hold_flag_o,
    output logic            wb_flag_o,
    output logic            store_flag_o,
    output logic            load_flag_o,
    output logic            LSU_signed_o,
    output logic [1:0]      LSU_type_o,
    output logic [4:0]      wb_addr_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [XLEN-1:0] operand_a_o,
    output logic [XLEN-1:0] operand_b_o,
    output logic [XLEN-1:0] operand_imm_o
);
    localparam int CW = $clog2(ITER);
    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
    localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [4:0]        md_op;
    logic [2*XLEN-1:0] acc;       // mul: {hi, multiplier/lo}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]   md_b;      // multiplicand or divisor magnitude
    logic              neg_q;     // negate product / quotient at the end
    logic              neg_r;     // negate remainder at the end
    logic              special;   // acc already holds the final signed result

    logic [XLEN-1:0]   src_b;
    logic [XLEN-1:0]   alu_res;
    logic              md_in;
    logic              md_start;
    logic              in_mul, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;

    assign src_b    = alu_src_imm_i ? operand_imm_i : operand_b_i;
    assign md_in    = (alu_op_i >= OP_MUL) && (alu_op_i <= OP_REMU);
    assign md_start = valid_i && md_in && !flush_i;
    assign in_mul   = alu_op_i <= OP_MULHU;
    assign a_signed = (alu_op_i == OP_MUL) || (alu_op_i == OP_MULH) || (alu_op_i == OP_MULHSU)
                   || (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
    assign b_signed = (alu_op_i == OP_MUL) || (alu_op_i == OP_MULH)
                   || (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
    assign a_neg    = a_signed && operand_a_i[XLEN-1];
    assign b_neg    = b_signed && src_b[XLEN-1];
    assign a_mag    = a_neg ? -operand_a_i : operand_a_i;
    assign b_mag    = b_neg ? -src_b : src_b;
    assign div_zero = !in_mul && (src_b == '0);
    assign div_ovf  = ((alu_op_i == OP_DIV) || (alu_op_i == OP_REM))
                   && (operand_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);

    always_comb begin
        alu_res = operand_a_i + src_b;
        case (alu_op_i)
            OP_SUB:  alu_res = operand_a_i - src_b;
            OP_SLL:  alu_res = operand_a_i << src_b[4:0];
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a_i) < $signed(src_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, operand_a_i < src_b};
            OP_XOR:  alu_res = operand_a_i ^ src_b;
            OP_SRL:  alu_res = operand_a_i >> src_b[4:0];
            OP_SRA:  alu_res = $unsigned($signed(operand_a_i) >>> src_b[4:0]);
            OP_OR:   alu_res = operand_a_i | src_b;
            OP_AND:  alu_res = operand_a_i & src_b;
            default: alu_res = operand_a_i + src_b;
        endcase
    end

    // One iteration step: shift-add multiply or restoring divide.
    logic            md_is_mul;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shl;
    logic            div_ge;
    logic [XLEN-1:0] div_sub;
    logic [2*XLEN-1:0] acc_next;

    assign md_is_mul = md_op <= OP_MULHU;
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, md_b} : '0);
    assign div_shl   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_ge    = div_shl >= {1'b0, md_b};
    // Partial remainder stays below the divisor, so the low bits of the difference are exact.
    assign div_sub   = div_shl[XLEN-1:0] - md_b;

    always_comb begin
        if (md_is_mul)
            acc_next = {mul_sum, acc[XLEN-1:1]};
        else if (div_ge)
            acc_next = {div_sub, acc[XLEN-2:0], 1'b1};
        else
            acc_next = {div_shl[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    // Sign correction applied while in DONE.
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   q_c, r_c, md_res, ex_res;

    assign prod_c = neg_q ? -acc : acc;
    assign q_c    = (neg_q && !special) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign r_c    = (neg_r && !special) ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        md_res = q_c;
        case (md_op)
            OP_MUL:                      md_res = prod_c[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod_c[2*XLEN-1:XLEN];
            OP_REM, OP_REMU:             md_res = r_c;
            default:                     md_res = q_c;
        endcase
    end

    assign ex_res = md_in ? md_res : alu_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            md_op   <= '0;
            acc     <= '0;
            md_b    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            special <= 1'b0;
        end else if (flush_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (md_start) begin
                        md_op   <= alu_op_i;
                        cnt     <= '0;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        special <= div_zero || div_ovf;
                        if (div_zero) begin
                            acc   <= {operand_a_i, {XLEN{1'b1}}};
                            state <= S_DONE;
                        end else if (div_ovf) begin
                            acc   <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                            state <= S_DONE;
                        end else begin
                            acc   <= in_mul ? {{XLEN{1'b0}}, b_mag} : {{XLEN{1'b0}}, a_mag};
                            md_b  <= in_mul ? a_mag : b_mag;
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (!lsu_hold_i)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ex_hold_flag_o = !flush_i && (((state == S_IDLE) && valid_i && md_in) || (state == S_BUSY));

    logic capture;
    assign capture = valid_i && !flush_i && (!md_in || (state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_flag_o     <= 1'b0;
            store_flag_o  <= 1'b0;
            load_flag_o   <= 1'b0;
            LSU_signed_o  <= 1'b0;
            LSU_type_o    <= '0;
            wb_addr_o     <= '0;
            wb_data_o     <= '0;
            operand_a_o   <= '0;
            operand_b_o   <= '0;
            operand_imm_o <= '0;
        end else if (!lsu_hold_i) begin
            wb_flag_o     <= capture && wb_flag_i;
            store_flag_o  <= capture && store_flag_i;
            load_flag_o   <= capture && load_flag_i;
            LSU_signed_o  <= capture && LSU_signed_i;
            LSU_type_o    <= capture ? LSU_type_i : 2'b0;
            wb_addr_o     <= capture ? wb_addr_i : 5'b0;
            wb_data_o     <= capture ? ex_res : '0;
            operand_a_o   <= capture ? operand_a_i : '0;
            operand_b_o   <= capture ? operand_b_i : '0;
            operand_imm_o <= capture ? operand_imm_i : '0;
        end
    end
endmodule

// File: tb/tb_ysyx_23060072_ex_stage.sv
// tb/tb_ysyx_23060072_ex_stage.sv - self-checking bench for ysyx_23060072_ex_stage
module tb_ysyx_23060072_ex_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid_i, alu_src_imm_i, wb_flag_i, store_flag_i, load_flag_i, LSU_signed_i;
    logic        lsu_hold_i, flush_i;
    logic [4:0]  alu_op_i, wb_addr_i;
    logic [1:0]  LSU_type_i;
    logic [31:0] operand_a_i, operand_b_i, operand_imm_i;
    logic        ex_hold_flag_o, wb_flag_o, store_flag_o, load_flag_o, LSU_signed_o;
    logic [1:0]  LSU_type_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o, operand_a_o, operand_b_o, operand_imm_o;

    ysyx_23060072_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_op_i(alu_op_i),
        .alu_src_imm_i(alu_src_imm_i), .wb_flag_i(wb_flag_i), .store_flag_i(store_flag_i),
        .load_flag_i(load_flag_i), .LSU_signed_i(LSU_signed_i), .LSU_type_i(LSU_type_i),
        .wb_addr_i(wb_addr_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .operand_imm_i(operand_imm_i), .lsu_hold_i(lsu_hold_i), .flush_i(flush_i),
        .ex_hold_flag_o(ex_hold_flag_o), .wb_flag_o(wb_flag_o), .store_flag_o(store_flag_o),
        .load_flag_o(load_flag_o), .LSU_signed_o(LSU_signed_o), .LSU_type_o(LSU_type_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .operand_a_o(operand_a_o),
        .operand_b_o(operand_b_o), .operand_imm_o(operand_imm_o)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        imm;
        logic [31:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic [31:0] opa;
        logic [1:0]  typ;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   got = 0;
    int   hold_seen = 0;
    int   tag = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: sample hold flag mid-cycle, then compare any fresh capture against the scoreboard.
    task automatic step();
        logic h;
        sb_t  e;
        #1;
        if (ex_hold_flag_o) hold_seen++;
        h = lsu_hold_i;
        @(posedge clk);
        #1;
        if (!h && wb_flag_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_capture", 64'(wb_data_o), 64'hDEAD_0000_0000_0000);
            end else begin
                e = sb_q.pop_front();
                chk("wb_data", 64'(wb_data_o), 64'(e.data));
                chk("wb_addr", 64'(wb_addr_o), 64'(e.addr));
                chk("operand_a", 64'(operand_a_o), 64'(e.opa));
                chk("lsu_type", 64'(LSU_type_o), 64'(e.typ));
                got++;
            end
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic imm);
        alu_op_i      = op;
        operand_a_i   = a;
        alu_src_imm_i = imm;
        operand_b_i   = imm ? ~b : b;
        operand_imm_i = imm ? b : ~b;
        wb_addr_i     = tag[4:0];
        LSU_type_i    = tag[1:0];
        wb_flag_i     = 1'b1;
        valid_i       = 1'b1;
        tag++;
    endtask

    task automatic push_exp(input logic [31:0] exp);
        sb_t e;
        e.data = exp;
        e.addr = wb_addr_i;
        e.opa  = operand_a_i;
        e.typ  = LSU_type_i;
        sb_q.push_back(e);
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic imm, input logic [31:0] exp,
                          input int lat, input int hold);
        int cyc;
        int g0;
        drive(op, a, b, imm);
        push_exp(exp);
        g0 = got;
        hold_seen = 0;
        cyc = 0;
        while (got == g0 && cyc < 100) begin
            step();
            cyc++;
        end
        valid_i = 1'b0;
        if (got == g0) sb_q.delete();
        chk({name, "_latency"}, 64'(cyc), 64'(lat));
        chk({name, "_hold_cycles"}, 64'(hold_seen), 64'(hold));
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] p;
        int cyc;
        int g0;

        vecs.push_back('{5'd0,  32'd5,        32'hFFFFFFF9, 1'b0, 32'hFFFFFFFE, 1, 0});
        vecs.push_back('{5'd1,  32'd10,       32'd3,        1'b0, 32'd7,        1, 0});
        vecs.push_back('{5'd2,  32'd1,        32'd35,       1'b1, 32'd8,        1, 0});
        vecs.push_back('{5'd3,  32'hFFFFFFFF, 32'd1,        1'b0, 32'd1,        1, 0});
        vecs.push_back('{5'd4,  32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        1, 0});
        vecs.push_back('{5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0, 1, 0});
        vecs.push_back('{5'd6,  32'h80000000, 32'd4,        1'b0, 32'h08000000, 1, 0});
        vecs.push_back('{5'd7,  32'h80000000, 32'd4,        1'b1, 32'hF8000000, 1, 0});
        vecs.push_back('{5'd8,  32'h000000F0, 32'h0000000F, 1'b1, 32'h000000FF, 1, 0});
        vecs.push_back('{5'd9,  32'h000000FF, 32'h0000003C, 1'b0, 32'h0000003C, 1, 0});
        vecs.push_back('{5'd31, 32'd2,        32'd3,        1'b0, 32'd5,        1, 0});
        vecs.push_back('{5'd10, 32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFEB, 34, 33});
        vecs.push_back('{5'd11, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 34, 33});
        vecs.push_back('{5'd12, 32'hFFFFFFFF, 32'd2,        1'b0, 32'hFFFFFFFF, 34, 33});
        vecs.push_back('{5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 34, 33});
        vecs.push_back('{5'd14, 32'd7,        32'd0,        1'b0, 32'hFFFFFFFF, 2, 1});
        vecs.push_back('{5'd16, 32'd7,        32'd0,        1'b0, 32'd7,        2, 1});
        vecs.push_back('{5'd14, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 2, 1});
        vecs.push_back('{5'd16, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        2, 1});
        vecs.push_back('{5'd15, 32'd7,        32'd0,        1'b0, 32'hFFFFFFFF, 2, 1});
        vecs.push_back('{5'd17, 32'd5,        32'd0,        1'b0, 32'd5,        2, 1});
        vecs.push_back('{5'd16, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 34, 33});
        vecs.push_back('{5'd14, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 34, 33});
        vecs.push_back('{5'd17, 32'd100,      32'd7,        1'b0, 32'd2,        34, 33});

        rst_n = 1'b0; valid_i = 1'b0; alu_op_i = '0; alu_src_imm_i = 1'b0;
        wb_flag_i = 1'b0; store_flag_i = 1'b0; load_flag_i = 1'b0; LSU_signed_i = 1'b0;
        LSU_type_i = '0; wb_addr_i = '0; operand_a_i = '0; operand_b_i = '0; operand_imm_i = '0;
        lsu_hold_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_data", {wb_data_o, operand_a_o}, 64'd0);
        chk("reset_ctrl", 64'({ex_hold_flag_o, wb_flag_o, store_flag_o, load_flag_o,
                               LSU_signed_o, LSU_type_o, wb_addr_o, operand_b_o, operand_imm_o}), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm,
                   vecs[i].exp, vecs[i].lat, vecs[i].hold);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom | 32'h1;
            p  = {32'b0, ra} * {32'b0, rb};
            run_op($sformatf("rnd_mulhu%0d", i), 5'd13, ra, rb, 1'b0, p[63:32], 34, 33);
            run_op($sformatf("rnd_divu%0d", i), 5'd15, ra, rb, 1'b0, ra / rb, 34, 33);
        end

        // DIVU 100/7 held in DONE by the LSU for five cycles.
        drive(5'd15, 32'd100, 32'd7, 1'b0);
        push_exp(32'd14);
        cyc = 0;
        step();
        cyc++;
        while (ex_hold_flag_o && cyc < 100) begin
            step();
            cyc++;
        end
        chk("divu_cycles_to_done", 64'(cyc), 64'd33);
        lsu_hold_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("divu_done_hold_low", 64'(ex_hold_flag_o), 64'd0);
            chk("divu_frozen_out", {31'b0, wb_flag_o, wb_data_o}, 64'd0);
        end
        lsu_hold_i = 1'b0;
        g0 = got;
        step();
        chk("divu_single_capture", 64'(got), 64'(g0 + 1));
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("divu_no_restart", {31'b0, ex_hold_flag_o, 31'b0, wb_flag_o}, 64'd0);
        end

        // Flush at BUSY cnt=10 with the LSU free.
        drive(5'd10, 32'd5, 32'd6, 1'b0);
        repeat (11) step();
        flush_i = 1'b1;
        #1;
        chk("flush_hold_drop", 64'(ex_hold_flag_o), 64'd0);
        step();
        chk("flush_bubble", {31'b0, wb_flag_o, wb_data_o}, 64'd0);
        flush_i = 1'b0;
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_idle", 64'(ex_hold_flag_o), 64'd0);
        end
        run_op("post_flush_mul", 5'd10, 32'd6, 32'd7, 1'b0, 32'd42, 34, 33);

        // Flush at BUSY cnt=10 with the LSU holding a finished ADD.
        run_op("pre_hold_add", 5'd0, 32'h11, 32'h22, 1'b0, 32'h33, 1, 0);
        lsu_hold_i = 1'b1;
        drive(5'd10, 32'd9, 32'd9, 1'b0);
        repeat (11) step();
        flush_i = 1'b1;
        #1;
        chk("flush_hold_drop2", 64'(ex_hold_flag_o), 64'd0);
        step();
        chk("flush_under_hold_keep", {31'b0, wb_flag_o, wb_data_o}, {31'b0, 1'b1, 32'h33});
        flush_i = 1'b0;
        valid_i = 1'b0;
        step();
        chk("hold_keep_after_flush", 64'(wb_data_o), 64'h33);
        lsu_hold_i = 1'b0;
        step();
        chk("bubble_after_release", 64'(wb_flag_o), 64'd0);

        // Asynchronous reset in the middle of a MUL.
        run_op("pre_reset_add", 5'd0, 32'h100, 32'h1, 1'b0, 32'h101, 1, 0);
        lsu_hold_i = 1'b1;
        drive(5'd10, 32'd3, 32'd3, 1'b0);
        repeat (5) step();
        chk("busy_before_reset", 64'(ex_hold_flag_o), 64'd1);
        #2;
        rst_n = 1'b0;
        valid_i = 1'b0;
        lsu_hold_i = 1'b0;
        #1;
        chk("async_reset_data", {wb_data_o, operand_a_o}, 64'd0);
        chk("async_reset_ctrl", 64'({ex_hold_flag_o, wb_flag_o, store_flag_o, load_flag_o,
                                     LSU_signed_o, LSU_type_o, wb_addr_o, operand_b_o, operand_imm_o}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op("post_reset_add", 5'd0, 32'd40, 32'd2, 1'b0, 32'd42, 1, 0);
        run_op("post_reset_mul", 5'd10, 32'd12, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFE8, 34, 33);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
